// File: rtl/id_scan_fsm_if.sv
// ---------------------------------------------------------------------------
// id_scan_fsm_if
// Character-stream and result bundle for the identifier scanner.
//
// Signals:
//   char_valid  source -> scanner  character qualifier
//   char        source -> scanner  8-bit ASCII character
//   out         scanner -> sink    1 while the run so far is a legal identifier
//   id_done     scanner -> sink    one-cycle pulse: legal identifier terminated
//   id_len      scanner -> sink    length of the terminated identifier
//   id_count    scanner -> sink    saturating count of completed identifiers
//   too_long    scanner -> sink    sticky over-length flag
//
// Modports:
//   master  character source / result consumer (lexer side)
//   slave   the scanner itself
// ---------------------------------------------------------------------------
interface id_scan_fsm_if #(
  parameter int LEN_W = 8,
  parameter int CNT_W = 8
);
  logic             char_valid;
  logic [7:0]       char;
  logic             out;
  logic             id_done;
  logic [LEN_W-1:0] id_len;
  logic [CNT_W-1:0] id_count;
  logic             too_long;

  modport master (
    output char_valid,
    output char,
    input  out,
    input  id_done,
    input  id_len,
    input  id_count,
    input  too_long
  );

  modport slave (
    input  char_valid,
    input  char,
    output out,
    output id_done,
    output id_len,
    output id_count,
    output too_long
  );
endinterface

// File: rtl/id_scan_fsm.sv
// ---------------------------------------------------------------------------
// id_scan_fsm
// Streaming identifier scanner. Consumes one character per qualified cycle
// and tracks whether the current run is a legal identifier: a letter
// followed by zero or more letters or digits, at most MAX_LEN characters.
// Any non-alphanumeric character is a separator and ends the run.
//
// Ports:
//   clk    input  system clock, rising edge
//   reset  input  synchronous active-high reset (overrides char_valid)
//   bus    id_scan_fsm_if.slave
//            char_valid/char in; out, id_done, id_len, id_count, too_long out
//
// Parameters:
//   MAX_LEN  longest legal identifier (1..255)
//   LEN_W    width of id_len, must hold MAX_LEN+1
//   CNT_W    width of the saturating identifier counter
//
// Build option:
//   ID_SCAN_UNDERSCORE_EN  when defined, '_' is classed as a letter;
//                          otherwise '_' is a separator.
//
// States:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | between tokens, no run in progress
//   S_IN_ID | run is a legal identifier so far (out=1)
//   S_BAD   | run started with a digit; discarded at next separator
//   S_LONG  | run exceeded MAX_LEN; discarded at next separator
// ---------------------------------------------------------------------------
module id_scan_fsm #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 8,
  parameter int CNT_W   = 8
) (
  input  logic          clk,
  input  logic          reset,
  id_scan_fsm_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_IN_ID = 2'd1,
    S_BAD   = 2'd2,
    S_LONG  = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] C_MAX_LEN = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  logic [LEN_W-1:0] r_len;
  logic             r_out;
  logic             r_id_done;
  logic [LEN_W-1:0] r_id_len;
  logic [CNT_W-1:0] r_id_count;
  logic             r_too_long;

  logic             w_is_lower;
  logic             w_is_upper;
  logic             w_is_letter;
  logic             w_is_digit;
  logic             w_is_alnum;

  // Character classification
  assign w_is_lower = (bus.char >= 8'h61) && (bus.char <= 8'h7A);
  assign w_is_upper = (bus.char >= 8'h41) && (bus.char <= 8'h5A);
  assign w_is_digit = (bus.char >= 8'h30) && (bus.char <= 8'h39);
`ifdef ID_SCAN_UNDERSCORE_EN
  assign w_is_letter = w_is_lower || w_is_upper || (bus.char == 8'h5F);
`else
  assign w_is_letter = w_is_lower || w_is_upper;
`endif
  assign w_is_alnum = w_is_letter || w_is_digit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_out      <= 1'b0;
      r_id_done  <= 1'b0;
      r_id_len   <= '0;
      r_id_count <= '0;
      r_too_long <= 1'b0;
    end else begin
      // id_done is a strobe; every other output holds unless a qualified
      // character below changes it.
      r_id_done <= 1'b0;
      if (bus.char_valid) begin
        case (r_state)
          S_IDLE: begin
            if (w_is_letter) begin
              r_state <= S_IN_ID;
              r_len   <= LEN_W'(1);
              r_out   <= 1'b1;
            end else if (w_is_digit) begin
              r_state <= S_BAD;
              r_len   <= '0;
              r_out   <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_len   <= '0;
              r_out   <= 1'b0;
            end
          end

          S_IN_ID: begin
            if (w_is_alnum) begin
              if (r_len < C_MAX_LEN) begin
                r_state <= S_IN_ID;
                r_len   <= r_len + LEN_W'(1);
                r_out   <= 1'b1;
              end else begin
                // MAX_LEN+1-th character: the run can no longer be legal
                r_state    <= S_LONG;
                r_len      <= '0;
                r_out      <= 1'b0;
                r_too_long <= 1'b1;
              end
            end else begin
              // Separator terminates a legal identifier, including one of
              // exactly MAX_LEN characters.
              r_state   <= S_IDLE;
              r_len     <= '0;
              r_out     <= 1'b0;
              r_id_done <= 1'b1;
              r_id_len  <= r_len;
              if (r_id_count != C_CNT_MAX) begin
                r_id_count <= r_id_count + CNT_W'(1);
              end
            end
          end

          S_BAD, S_LONG: begin
            r_out <= 1'b0;
            r_len <= '0;
            if (!w_is_alnum) begin
              r_state <= S_IDLE;
            end
          end

          default: begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_out   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.out      = r_out;
  assign bus.id_done  = r_id_done;
  assign bus.id_len   = r_id_len;
  assign bus.id_count = r_id_count;
  assign bus.too_long = r_too_long;

endmodule
